// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared state encoding and default sizes for insn_loader.
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/loader_csum.sv
`default_nettype none
// ============================================================================
//  Module      : loader_csum
//  Description : Running mod-2^XLEN sum of program words and final compare.
//  Revision    : 1.0  initial release
// ============================================================================
module loader_csum #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            add_i,
    input  logic [XLEN-1:0] data_i,
    output logic            match_o
);

    logic [XLEN-1:0] sum_q;
    logic [XLEN-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match_o = (sum_q == data_i);

endmodule
`default_nettype wire

// File: rtl/insn_loader.sv
`default_nettype none
// ============================================================================
//  Module      : insn_loader
//  Description : Zero-fills instruction memory, streams a program into it,
//                then releases the core reset. LOADER_CHECKSUM_EN adds a
//                trailing checksum beat verified before release.
//  Revision    : 1.0  initial release
// ============================================================================
module insn_loader
    import loader_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     word_count,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [XLEN-1:0] s_data,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            core_reset,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [AW:0]   ONE_W     = (AW+1)'(1);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_LOAD = ST_CHECK;
`else
    localparam state_t ST_AFTER_LOAD = ST_RUN;
`endif

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     wc_q, wc_d;
    logic            s_ready_q, s_ready_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            core_reset_q, core_reset_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            w_beat;

    assign w_beat = s_valid && s_ready_q;

`ifdef LOADER_CHECKSUM_EN
    logic w_start_ok;
    logic w_csum_add;
    logic w_csum_match;

    assign w_start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                                  (state_q == ST_ERR));
    assign w_csum_add = (state_q == ST_LOAD) && w_beat;

    loader_csum #(.XLEN(XLEN)) u_csum (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (w_start_ok),
        .add_i   (w_csum_add),
        .data_i  (s_data),
        .match_o (w_csum_match)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wc_d        = wc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    wc_d = word_count;
                    if (word_count > DEPTH_W) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d     = ST_CLEAR;
                        cnt_d       = '0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                    end
                end
            end
            // cnt_q holds the address of the clear write currently visible.
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = (wc_q == '0) ? ST_AFTER_LOAD : ST_LOAD;
                end else begin
                    cnt_d       = cnt_q + ONE_A;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q + ONE_A;
                    mem_wdata_d = '0;
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = s_data;
                    cnt_d       = cnt_q + ONE_A;
                    if ({1'b0, cnt_q} == (wc_q - ONE_W)) begin
                        state_d = ST_AFTER_LOAD;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_beat) begin
                    state_d = w_csum_match ? ST_RUN : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered.
        s_ready_d    = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        busy_d       = (state_d == ST_CLEAR) || (state_d == ST_LOAD) ||
                       (state_d == ST_CHECK);
        err_d        = (state_d == ST_ERR);
        // Release waits one cycle in RUN so the last write lands first.
        done_d       = (state_d == ST_RUN) && (state_q == ST_RUN);
        core_reset_d = done_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wc_q         <= '0;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wc_q         <= wc_d;
            s_ready_q    <= s_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_insn_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_insn_loader
//  Description : Cycle-table bench for insn_loader at DEPTH=16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_insn_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  word_count;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    insn_loader #(.XLEN(32), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // One record per cycle: inputs driven this cycle, outputs expected this cycle.
    typedef struct {
        logic        start;
        logic [4:0]  wc;
        logic        valid;
        logic [31:0] data;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic        rdy;
        logic        crst;
        logic        bsy;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] prog[$];
    int          checks = 0;
    int          errors = 0;

    task automatic push(input logic st, input logic [4:0] wc, input logic v,
                        input logic [31:0] d, input logic we, input logic [3:0] a,
                        input logic [31:0] wd, input logic rdy, input logic crst,
                        input logic bsy, input logic dn, input logic er);
        vec_t e;
        e.start = st; e.wc = wc; e.valid = v; e.data = d;
        e.we = we; e.addr = a; e.wd = wd; e.rdy = rdy;
        e.crst = crst; e.bsy = bsy; e.dn = dn; e.er = er;
        tbl.push_back(e);
    endtask

    task automatic check_out(input string name, input vec_t e);
        bit ok;
        checks++;
        ok = (mem_we === e.we) && (s_ready === e.rdy) && (core_reset === e.crst) &&
             (busy === e.bsy) && (done === e.dn) && (err === e.er);
        if (e.we) ok = ok && (mem_addr === e.addr) && (mem_wdata === e.wd);
        if (!ok) begin
            errors++;
            $display("FAIL %s: got we=%b addr=%0d wdata=%h rdy=%b crst=%b busy=%b done=%b err=%b; want we=%b addr=%0d wdata=%h rdy=%b crst=%b busy=%b done=%b err=%b",
                     name, mem_we, mem_addr, mem_wdata, s_ready, core_reset, busy, done, err,
                     e.we, e.addr, e.wd, e.rdy, e.crst, e.bsy, e.dn, e.er);
        end
    endtask

    task automatic run_table(input string tname);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            check_out($sformatf("%s[%0d]", tname, i), tbl[i]);
            start      = tbl[i].start;
            word_count = tbl[i].wc;
            s_valid    = tbl[i].valid;
            s_data     = tbl[i].data;
        end
        tbl.delete();
    endtask

    // Full sequence from an accepted start; pd/pe are done/err before the start.
    task automatic build_seq(input logic [4:0] wc, input bit gap, input logic [31:0] csum,
                             input bit csum_ok, input logic pd, input logic pe);
        logic        pend;
        logic [3:0]  pa;
        logic [31:0] pdat;
        push(1'b1, wc, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, pd, 1'b0, pd, pe);
        for (int k = 0; k < 16; k++)
            push(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 4'(k), 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pend = 1'b0; pa = 4'd0; pdat = 32'h0;
        for (int i = 0; i < int'(wc); i++) begin
            if (gap) begin
                push(1'b0, 5'd0, 1'b0, 32'h0, pend, pa, pdat, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                pend = 1'b0;
            end
            push(1'b0, 5'd0, 1'b1, prog[i], pend, pa, pdat, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            pend = 1'b1; pa = 4'(i); pdat = prog[i];
        end
`ifdef LOADER_CHECKSUM_EN
        push(1'b0, 5'd0, 1'b1, csum, pend, pa, pdat, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        if (csum_ok) begin
            push(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
            push(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            push(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
`else
        if (csum_ok || csum == 32'h0) begin end
        push(1'b0, 5'd0, 1'b0, 32'h0, pend, pa, pdat, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    vec_t zero_v;

    initial begin
        zero_v = '{default: '0};
        reset = 1'b0; start = 1'b0; word_count = 5'd0; s_valid = 1'b0; s_data = 32'h0;
        repeat (2) @(negedge clk);
        check_out("reset_state", zero_v);
        reset = 1'b1;

        prog = '{32'h03208093, 32'h00110113, 32'h4020A1B3};
        build_seq(5'd3, 1'b0, 32'h43522359, 1'b1, 1'b0, 1'b0);
        run_table("b2b");
        build_seq(5'd3, 1'b1, 32'h43522359, 1'b1, 1'b1, 1'b0);
        run_table("gaps");

        prog.delete();
        build_seq(5'd0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        run_table("empty");

        push(1'b1, 5'd17, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            push(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_table("oversize");
        prog = '{32'hDEADBEEF};
        build_seq(5'd1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        run_table("after_err");

        // Async reset while the second program word's write is visible.
        prog = '{32'h03208093, 32'h00110113, 32'h4020A1B3};
        push(1'b1, 5'd3, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++)
            push(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 4'(k), 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b0, 5'd0, 1'b1, prog[0], 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b0, 5'd0, 1'b1, prog[1], 1'b1, 4'd0, prog[0], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_table("pre_rst");
        @(negedge clk);
        check_out("word1_write", '{1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 4'd1, 32'h00110113,
                                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        s_valid = 1'b0;
        #1 reset = 1'b0;
        #1 check_out("async_rst", zero_v);
        @(negedge clk);
        check_out("rst_hold", zero_v);
        reset = 1'b1;
        build_seq(5'd3, 1'b0, 32'h43522359, 1'b1, 1'b0, 1'b0);
        run_table("reload");

`ifdef LOADER_CHECKSUM_EN
        build_seq(5'd3, 1'b0, 32'h43522358, 1'b0, 1'b1, 1'b0);
        run_table("bad_csum");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
